controle_elevador: RTL and testbench
====================================

Name: controle_elevador

Overview:
- Sequential controller for the 4-floor elevator. It holds the current floor register and the latched hall/cabin requests.
- It drives them into the combinational output-decision stage as AndarB1/AndarB0/At/A1/A2/A3.
- It consumes that stage's Su/De/PA decisions to sequence the motor, floor travel timing and door timing.
- It sits directly upstream of the decision logic and closes the loop with it.

Parameters:
- T_VIAGEM, 4, clock cycles of motor travel per floor (legal 1..15, 4-bit timer)
- T_PORTA, 3, clock cycles the door stays open (legal 1..15, 4-bit timer)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- Bt  input  1  call button, ground floor (level; sampled every cycle)
- B1  input  1  call button, floor 1
- B2  input  1  call button, floor 2
- B3  input  1  call button, floor 3
- Su  input  1  "go up" decision from output-decision stage
- De  input  1  "go down" decision from output-decision stage
- PA  input  1  "open door" decision from output-decision stage
- AndarB1  output  1  current floor, MSB (registered)
- AndarB0  output  1  current floor, LSB (registered)
- At  output  1  pending request, ground floor (registered)
- A1  output  1  pending request, floor 1 (registered)
- A2  output  1  pending request, floor 2 (registered)
- A3  output  1  pending request, floor 3 (registered)
- Motor_Su  output  1  motor up drive, high only in SUBINDO
- Motor_De  output  1  motor down drive, high only in DESCENDO
- Porta  output  1  door open, high only in PORTA
- Estado  output  2  FSM state: 00 PARADO, 01 SUBINDO, 10 DESCENDO, 11 PORTA

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - floor = 0; At..A3 = 0; both timers = 0; Estado = PARADO.
  - Motor_Su, Motor_De and Porta = 0.
  - Reset mid-travel or mid-door aborts immediately. Pending requests are discarded.
- Request latches:
  - Each cycle, req[i] <= (req[i] | button[i]) & ~clear[i].
  - clear[i] is asserted only on the PARADO->PORTA transition, for i == floor.
  - If set and clear hit the same bit in the same cycle, clear wins.
  - While in PORTA, the button for the current floor is not latched. It reloads the door timer to T_PORTA instead.
  - Buttons for other floors latch in every state.
  - A button high at edge n gives a request bit high from cycle n+1 on.
- FSM: PARADO, SUBINDO, DESCENDO, PORTA.
  - PARADO, decision priority PA > Su > De:
    - PA=1: go to PORTA, clear req[floor], door timer <= T_PORTA.
    - Else Su=1 and floor != 3: go to SUBINDO, travel timer <= T_VIAGEM.
    - Else De=1 and floor != 0: go to DESCENDO, travel timer <= T_VIAGEM.
    - Else stay in PARADO.
    - Su at floor 3 and De at floor 0 are ignored (guard against illegal decisions).
  - SUBINDO:
    - Travel timer decrements by 1 each cycle.
    - In the cycle the timer equals 1: floor <= floor+1 and go to PARADO.
    - Su/De/PA are ignored while moving.
  - DESCENDO: same as SUBINDO with floor <= floor-1.
  - PORTA:
    - Door timer decrements by 1 each cycle.
    - In the cycle the timer equals 1 and there is no same-floor button: go to PARADO.
    - A same-floor button reloads the timer, so the door stays open.
- Timing:
  - Each floor of travel costs exactly T_VIAGEM cycles in SUBINDO/DESCENDO plus 1 PARADO cycle.
  - The door stays open exactly T_PORTA cycles.
- Floor arithmetic:
  - 2-bit unsigned. No wrap is possible because of the guards.
  - AndarB1/AndarB0 change only on motor-timer expiry.
- PF from the decision stage is not consumed.
- Motor_Su and Motor_De are never high together. Porta is never high while either motor output is high.

Test Plan:
- Reset: assert rst 2 cycles, with buttons toggling during reset.
  -> All outputs 0 and Estado=00. No request latched afterwards from the reset-time presses.
- Upward trip (T_VIAGEM=4, T_PORTA=3, loop closed with the decision stage): floor 0, pulse B2 one cycle.
  -> A2=1 next cycle.
  -> Motor_Su high 4 cycles, floor=1, 1 PARADO cycle, Motor_Su high 4 more cycles, floor=2.
  -> Next cycle Porta=1 and A2=0. Porta stays high 3 cycles, then Estado=00.
- Downward trip: floor 3, pulse Bt.
  -> Three DESCENDO legs of 4 cycles each, floor sequence 3,2,1,0.
  -> Then Porta=1 for 3 cycles and At cleared.
- Door hold: in PORTA at floor 1, press B1 at door-timer value 1.
  -> Porta stays high 3 further cycles and A1 remains 0.
- Simultaneous requests: floor 1, press B0-floor Bt and B3 in the same cycle.
  -> Both latch. Direction follows Su/De from the decision stage. Requests clear only on arrival at their own floor.
- Illegal decision guard: force Su=1 at floor 3 and De=1 at floor 0.
  -> Estado stays 00 and the floor is unchanged.
  -> Reset asserted mid-SUBINDO: next cycle floor=0 and Motor_Su=0.

Source files
------------

// File: rtl/controle_elevador_if.sv
// Signal bundle between the elevator controller and its surroundings:
// call buttons, the decision-stage outputs, and the controller's registered state.
interface controle_elevador_if;
    logic       Bt, B1, B2, B3;
    logic       Su, De, PA;
    logic       AndarB1, AndarB0;
    logic       At, A1, A2, A3;
    logic       Motor_Su, Motor_De, Porta;
    logic [1:0] Estado;

    modport master (
        output Bt, B1, B2, B3, Su, De, PA,
        input  AndarB1, AndarB0, At, A1, A2, A3, Motor_Su, Motor_De, Porta, Estado
    );

    modport slave (
        input  Bt, B1, B2, B3, Su, De, PA,
        output AndarB1, AndarB0, At, A1, A2, A3, Motor_Su, Motor_De, Porta, Estado
    );
endinterface

// File: rtl/controle_elevador.sv
// Four-floor elevator controller: floor register, latched calls, and the
// motor/door sequencer driven by the external Su/De/PA decision stage.
module controle_elevador #(
    parameter int unsigned T_VIAGEM = 4,
    parameter int unsigned T_PORTA  = 3
) (
    input  logic              clk,
    input  logic              rst,
    controle_elevador_if.slave elev
);

    typedef enum logic [1:0] {
        PARADO   = 2'b00,
        SUBINDO  = 2'b01,
        DESCENDO = 2'b10,
        PORTA    = 2'b11
    } estadoT;

    localparam logic [3:0] viagemLoad = 4'(T_VIAGEM);
    localparam logic [3:0] portaLoad  = 4'(T_PORTA);

    estadoT     estado, estadoNext;
    logic [1:0] andar, andarNext;
    logic [3:0] req, reqNext;
    logic [3:0] timerViagem, timerViagemNext;
    logic [3:0] timerPorta, timerPortaNext;
    logic [3:0] botoes, setMask, clearMask;

    assign botoes = {elev.B3, elev.B2, elev.B1, elev.Bt};

    // NOTE: reset is synchronous and covers every state bit, so a reset in the
    // middle of a trip or door cycle aborts it and drops all pending calls.
    // NOTE: non-blocking assignments here so all registers update from the same
    // pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado      <= PARADO;
            andar       <= 2'd0;
            req         <= 4'd0;
            timerViagem <= 4'd0;
            timerPorta  <= 4'd0;
        end else begin
            estado      <= estadoNext;
            andar       <= andarNext;
            req         <= reqNext;
            timerViagem <= timerViagemNext;
            timerPorta  <= timerPortaNext;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        estadoNext      = estado;
        andarNext       = andar;
        timerViagemNext = timerViagem;
        timerPortaNext  = timerPorta;
        setMask         = botoes;
        clearMask       = 4'd0;

        unique case (estado)
            PARADO: begin
                if (elev.PA) begin
                    estadoNext       = PORTA;
                    timerPortaNext   = portaLoad;
                    clearMask[andar] = 1'b1;
                end else if (elev.Su && andar != 2'd3) begin
                    estadoNext      = SUBINDO;
                    timerViagemNext = viagemLoad;
                end else if (elev.De && andar != 2'd0) begin
                    estadoNext      = DESCENDO;
                    timerViagemNext = viagemLoad;
                end
            end
            SUBINDO, DESCENDO: begin
                timerViagemNext = timerViagem - 4'd1;
                if (timerViagem == 4'd1) begin
                    estadoNext = PARADO;
                    andarNext  = (estado == SUBINDO) ? andar + 2'd1 : andar - 2'd1;
                end
            end
            PORTA: begin
                // A call for the floor we are standing on keeps the door open
                // rather than being recorded as a new request.
                setMask[andar] = 1'b0;
                if (botoes[andar]) begin
                    timerPortaNext = portaLoad;
                end else begin
                    timerPortaNext = timerPorta - 4'd1;
                    if (timerPorta == 4'd1) estadoNext = PARADO;
                end
            end
            default: estadoNext = PARADO;
        endcase

        reqNext = (req | setMask) & ~clearMask;
    end

    assign elev.AndarB1  = andar[1];
    assign elev.AndarB0  = andar[0];
    assign elev.At       = req[0];
    assign elev.A1       = req[1];
    assign elev.A2       = req[2];
    assign elev.A3       = req[3];
    assign elev.Motor_Su = (estado == SUBINDO);
    assign elev.Motor_De = (estado == DESCENDO);
    assign elev.Porta    = (estado == PORTA);
    assign elev.Estado   = estado;

endmodule

// File: tb/tb_controle_elevador.sv
// Directed bench for controle_elevador with a simple decision stage closing the loop.
module tb_controle_elevador;

    localparam int T_VIAGEM = 4;
    localparam int T_PORTA  = 3;
    localparam logic [1:0] PAR = 2'd0, SUB = 2'd1, DES = 2'd2, POR = 2'd3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    controle_elevador_if ifc ();

    controle_elevador #(.T_VIAGEM(T_VIAGEM), .T_PORTA(T_PORTA)) dut (
        .clk  (clk),
        .rst  (rst),
        .elev (ifc.slave)
    );

    int checks = 0;
    int errors = 0;

    // Decision stage: open on own-floor call, otherwise up if any call above, down if below.
    logic       manual, manSu, manDe, manPA;
    logic       autoSu, autoDe, autoPA;
    logic [3:0] reqs;
    logic [1:0] floorObs;
    assign reqs     = {ifc.A3, ifc.A2, ifc.A1, ifc.At};
    assign floorObs = {ifc.AndarB1, ifc.AndarB0};
    always_comb begin
        autoPA = reqs[floorObs];
        autoSu = 1'b0;
        autoDe = 1'b0;
        case (floorObs)
            2'd0: autoSu = |reqs[3:1];
            2'd1: begin autoSu = |reqs[3:2]; autoDe = reqs[0];    end
            2'd2: begin autoSu = reqs[3];    autoDe = |reqs[1:0]; end
            default: autoDe = |reqs[2:0];
        endcase
    end
    assign ifc.Su = manual ? manSu : autoSu;
    assign ifc.De = manual ? manDe : autoDe;
    assign ifc.PA = manual ? manPA : autoPA;

    logic [10:0] observed, expected;
    assign observed = {ifc.Estado, ifc.AndarB1, ifc.AndarB0, ifc.A3, ifc.A2, ifc.A1, ifc.At,
                       ifc.Motor_Su, ifc.Motor_De, ifc.Porta};

    function automatic logic [10:0] st(input logic [1:0] e, input logic [1:0] f, input logic [3:0] r);
        return {e, f, r, e == SUB, e == DES, e == POR};
    endfunction

    task automatic press(input logic [3:0] b);
        {ifc.B3, ifc.B2, ifc.B1, ifc.Bt} = b;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        manual = 1'b1; manSu = 1'b0; manDe = 1'b0; manPA = 1'b0;
        rst = 1'b1;
        press(4'b0101); step();
        press(4'b1010); step();
        press(4'b0000); rst = 1'b0;
        expected = st(PAR, 2'd0, 4'b0000);
        checks++; if (observed !== expected) begin errors++; $display("FAIL reset_state: got %b expected %b", observed, expected); end
        manual = 1'b0;
        step();
        checks++; if (observed !== expected) begin errors++; $display("FAIL reset_no_latch: got %b expected %b", observed, expected); end
    endtask

    task automatic test_up_trip();
        press(4'b0100); step(); press(4'b0000);
        expected = st(PAR, 2'd0, 4'b0100);
        checks++; if (observed !== expected) begin errors++; $display("FAIL up_latch: got %b expected %b", observed, expected); end
        for (int leg = 0; leg < 2; leg++) begin
            for (int i = 0; i < T_VIAGEM; i++) begin
                step(); expected = st(SUB, 2'(leg), 4'b0100);
                checks++; if (observed !== expected) begin errors++; $display("FAIL up_move leg%0d c%0d: got %b expected %b", leg, i, observed, expected); end
            end
            step(); expected = st(PAR, 2'(leg + 1), 4'b0100);
            checks++; if (observed !== expected) begin errors++; $display("FAIL up_arrive leg%0d: got %b expected %b", leg, observed, expected); end
        end
        for (int i = 0; i < T_PORTA; i++) begin
            step(); expected = st(POR, 2'd2, 4'b0000);
            checks++; if (observed !== expected) begin errors++; $display("FAIL up_door c%0d: got %b expected %b", i, observed, expected); end
        end
        step(); expected = st(PAR, 2'd2, 4'b0000);
        checks++; if (observed !== expected) begin errors++; $display("FAIL up_close: got %b expected %b", observed, expected); end
    endtask

    task automatic test_door_hold();
        press(4'b0010); step(); press(4'b0000);
        expected = st(PAR, 2'd2, 4'b0010);
        checks++; if (observed !== expected) begin errors++; $display("FAIL hold_latch: got %b expected %b", observed, expected); end
        for (int i = 0; i < T_VIAGEM; i++) begin
            step(); expected = st(DES, 2'd2, 4'b0010);
            checks++; if (observed !== expected) begin errors++; $display("FAIL hold_move c%0d: got %b expected %b", i, observed, expected); end
        end
        step(); expected = st(PAR, 2'd1, 4'b0010);
        checks++; if (observed !== expected) begin errors++; $display("FAIL hold_arrive: got %b expected %b", observed, expected); end
        // Three door cycles: timer 3, 2, 1; press the own-floor button while at 1.
        for (int i = 0; i < T_PORTA; i++) begin
            step(); expected = st(POR, 2'd1, 4'b0000);
            checks++; if (observed !== expected) begin errors++; $display("FAIL hold_door c%0d: got %b expected %b", i, observed, expected); end
        end
        press(4'b0010);
        for (int i = 0; i < T_PORTA; i++) begin
            step(); if (i == 0) press(4'b0000);
            expected = st(POR, 2'd1, 4'b0000);
            checks++; if (observed !== expected) begin errors++; $display("FAIL hold_reload c%0d: got %b expected %b", i, observed, expected); end
        end
        step(); expected = st(PAR, 2'd1, 4'b0000);
        checks++; if (observed !== expected) begin errors++; $display("FAIL hold_close: got %b expected %b", observed, expected); end
    endtask

    task automatic test_down_trip();
        press(4'b1000); step(); press(4'b0000);
        for (int leg = 0; leg < 2; leg++) begin
            for (int i = 0; i < T_VIAGEM; i++) begin
                step(); expected = st(SUB, 2'(leg + 1), 4'b1000);
                checks++; if (observed !== expected) begin errors++; $display("FAIL pre_up leg%0d c%0d: got %b expected %b", leg, i, observed, expected); end
            end
            step();
        end
        for (int i = 0; i <= T_PORTA; i++) step();
        expected = st(PAR, 2'd3, 4'b0000);
        checks++; if (observed !== expected) begin errors++; $display("FAIL down_start: got %b expected %b", observed, expected); end
        press(4'b0001); step(); press(4'b0000);
        expected = st(PAR, 2'd3, 4'b0001);
        checks++; if (observed !== expected) begin errors++; $display("FAIL down_latch: got %b expected %b", observed, expected); end
        for (int leg = 0; leg < 3; leg++) begin
            for (int i = 0; i < T_VIAGEM; i++) begin
                step(); expected = st(DES, 2'(3 - leg), 4'b0001);
                checks++; if (observed !== expected) begin errors++; $display("FAIL down_move leg%0d c%0d: got %b expected %b", leg, i, observed, expected); end
            end
            step(); expected = st(PAR, 2'(2 - leg), 4'b0001);
            checks++; if (observed !== expected) begin errors++; $display("FAIL down_arrive leg%0d: got %b expected %b", leg, observed, expected); end
        end
        for (int i = 0; i < T_PORTA; i++) begin
            step(); expected = st(POR, 2'd0, 4'b0000);
            checks++; if (observed !== expected) begin errors++; $display("FAIL down_door c%0d: got %b expected %b", i, observed, expected); end
        end
        step(); expected = st(PAR, 2'd0, 4'b0000);
        checks++; if (observed !== expected) begin errors++; $display("FAIL down_close: got %b expected %b", observed, expected); end
    endtask

    task automatic test_simultaneous();
        press(4'b0010); step(); press(4'b0000);
        for (int i = 0; i <= T_VIAGEM + T_PORTA + 1; i++) step();
        expected = st(PAR, 2'd1, 4'b0000);
        checks++; if (observed !== expected) begin errors++; $display("FAIL sim_start: got %b expected %b", observed, expected); end
        press(4'b1001); step(); press(4'b0000);
        expected = st(PAR, 2'd1, 4'b1001);
        checks++; if (observed !== expected) begin errors++; $display("FAIL sim_latch: got %b expected %b", observed, expected); end
        for (int leg = 0; leg < 2; leg++) begin
            for (int i = 0; i < T_VIAGEM; i++) begin
                step(); expected = st(SUB, 2'(leg + 1), 4'b1001);
                checks++; if (observed !== expected) begin errors++; $display("FAIL sim_up leg%0d c%0d: got %b expected %b", leg, i, observed, expected); end
            end
            step(); expected = st(PAR, 2'(leg + 2), 4'b1001);
            checks++; if (observed !== expected) begin errors++; $display("FAIL sim_up_arrive leg%0d: got %b expected %b", leg, observed, expected); end
        end
        for (int i = 0; i < T_PORTA; i++) begin
            step(); expected = st(POR, 2'd3, 4'b0001);
            checks++; if (observed !== expected) begin errors++; $display("FAIL sim_door3 c%0d: got %b expected %b", i, observed, expected); end
        end
        step(); expected = st(PAR, 2'd3, 4'b0001);
        checks++; if (observed !== expected) begin errors++; $display("FAIL sim_close3: got %b expected %b", observed, expected); end
        for (int leg = 0; leg < 3; leg++) begin
            for (int i = 0; i < T_VIAGEM; i++) begin
                step(); expected = st(DES, 2'(3 - leg), 4'b0001);
                checks++; if (observed !== expected) begin errors++; $display("FAIL sim_down leg%0d c%0d: got %b expected %b", leg, i, observed, expected); end
            end
            step();
        end
        step(); expected = st(POR, 2'd0, 4'b0000);
        checks++; if (observed !== expected) begin errors++; $display("FAIL sim_door0: got %b expected %b", observed, expected); end
        for (int i = 0; i < T_PORTA; i++) step();
    endtask

    task automatic test_illegal_guard();
        manual = 1'b1; manSu = 1'b0; manDe = 1'b1; manPA = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); expected = st(PAR, 2'd0, 4'b0000);
            checks++; if (observed !== expected) begin errors++; $display("FAIL guard_de0 c%0d: got %b expected %b", i, observed, expected); end
        end
        manSu = 1'b1; manDe = 1'b0;
        for (int leg = 0; leg < 3; leg++) begin
            for (int i = 0; i <= T_VIAGEM; i++) step();
        end
        for (int i = 0; i < 3; i++) begin
            step(); expected = st(PAR, 2'd3, 4'b0000);
            checks++; if (observed !== expected) begin errors++; $display("FAIL guard_su3 c%0d: got %b expected %b", i, observed, expected); end
        end
    endtask

    task automatic test_reset_mid_travel();
        rst = 1'b1; step(); rst = 1'b0;
        expected = st(PAR, 2'd0, 4'b0000);
        checks++; if (observed !== expected) begin errors++; $display("FAIL rst_from3: got %b expected %b", observed, expected); end
        for (int i = 0; i <= T_VIAGEM; i++) step();
        press(4'b0100);
        step(); press(4'b0000); step();
        expected = st(SUB, 2'd1, 4'b0100);
        checks++; if (observed !== expected) begin errors++; $display("FAIL rst_pre: got %b expected %b", observed, expected); end
        rst = 1'b1; manSu = 1'b0; step(); rst = 1'b0;
        expected = st(PAR, 2'd0, 4'b0000);
        checks++; if (observed !== expected) begin errors++; $display("FAIL rst_mid_sub: got %b expected %b", observed, expected); end
        step();
        checks++; if (observed !== expected) begin errors++; $display("FAIL rst_after: got %b expected %b", observed, expected); end
    endtask

    initial begin
        press(4'b0000);
        test_reset();
        test_up_trip();
        test_door_hold();
        test_down_trip();
        test_simultaneous();
        test_illegal_guard();
        test_reset_mid_travel();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
